// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into 32-bit
// words and issues single-cycle word writes with an auto-incrementing address.
module uart_prog_loader #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  uartRx,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           din,
    output logic [3:0]            we,
    output logic                  busy,
    output logic                  frameErr,
    output logic [ADDR_WIDTH:0]   wordCount
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [ADDR_WIDTH:0] WC_MAX = {(ADDR_WIDTH+1){1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t                state_r;
    logic                  rx_meta_r;
    logic                  rx_sync_r;
    logic                  en_d_r;
    logic                  armed_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [2:0]            bit_idx_r;
    logic [1:0]            byte_idx_r;
    logic [7:0]            shift_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           din_r;
    logic [3:0]            we_r;
    logic                  busy_r;
    logic                  frame_err_r;
    logic [ADDR_WIDTH:0]   word_cnt_r;
    logic                  rx_s;

    assign rx_s      = rx_sync_r;
    assign addr      = addr_r;
    assign din       = din_r;
    assign we        = we_r;
    assign busy      = busy_r;
    assign frameErr  = frame_err_r;
    assign wordCount = word_cnt_r;

    // Two-flop synchronizer for the asynchronous serial line (idle high).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uartRx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive/assemble/write state machine with all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            en_d_r      <= 1'b0;
            armed_r     <= 1'b0;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            byte_idx_r  <= 2'd0;
            shift_r     <= 8'h00;
            addr_r      <= '0;
            din_r       <= 32'h0000_0000;
            we_r        <= 4'h0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            word_cnt_r  <= '0;
        end else begin
            en_d_r <= en;
            // A new start bit is only honoured after the line was seen high.
            if (rx_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end

            if (!en) begin
                state_r    <= ST_IDLE;
                byte_idx_r <= 2'd0;
                we_r       <= 4'h0;
                busy_r     <= 1'b0;
                cnt_r      <= '0;
                // The write presented this cycle still lands, so account for it.
                if (state_r == ST_WRITE) begin
                    addr_r <= addr_r + ADDR_WIDTH'(1);
                    if (word_cnt_r != WC_MAX) begin
                        word_cnt_r <= word_cnt_r + (ADDR_WIDTH+1)'(1);
                    end else begin
                        word_cnt_r <= word_cnt_r;
                    end
                end else begin
                    addr_r <= addr_r;
                end
            end else if (!en_d_r) begin
                state_r     <= ST_IDLE;
                addr_r      <= '0;
                word_cnt_r  <= '0;
                frame_err_r <= 1'b0;
                byte_idx_r  <= 2'd0;
                we_r        <= 4'h0;
                busy_r      <= 1'b0;
                cnt_r       <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        we_r <= 4'h0;
                        if (!rx_s && armed_r) begin
                            state_r <= ST_START;
                            cnt_r   <= '0;
                            busy_r  <= 1'b1;
                        end else begin
                            busy_r <= (byte_idx_r != 2'd0);
                        end
                    end
                    ST_START: begin
                        if (cnt_r == CNT_MID) begin
                            cnt_r <= '0;
                            if (rx_s) begin
                                state_r <= ST_IDLE;
                                busy_r  <= (byte_idx_r != 2'd0);
                            end else begin
                                state_r   <= ST_DATA;
                                bit_idx_r <= 3'd0;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (cnt_r == CNT_LAST) begin
                            cnt_r   <= '0;
                            shift_r <= {rx_s, shift_r[7:1]};
                            if (bit_idx_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (cnt_r == CNT_LAST) begin
                            cnt_r   <= '0;
                            armed_r <= 1'b0;
                            if (rx_s) begin
                                din_r[{byte_idx_r, 3'b000} +: 8] <= shift_r;
                                busy_r <= 1'b1;
                                if (byte_idx_r == 2'd3) begin
                                    state_r <= ST_WRITE;
                                    we_r    <= 4'hF;
                                end else begin
                                    state_r    <= ST_IDLE;
                                    byte_idx_r <= byte_idx_r + 2'd1;
                                end
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= ST_IDLE;
                                busy_r      <= (byte_idx_r != 2'd0);
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_WRITE: begin
                        we_r       <= 4'h0;
                        addr_r     <= addr_r + ADDR_WIDTH'(1);
                        byte_idx_r <= 2'd0;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        if (word_cnt_r != WC_MAX) begin
                            word_cnt_r <= word_cnt_r + (ADDR_WIDTH+1)'(1);
                        end else begin
                            word_cnt_r <= word_cnt_r;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        we_r    <= 4'h0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader against a queue-based reference of bytes/words.
module tb_uart_prog_loader;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int AW       = 2;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int WC_MAX   = (1 << (AW + 1)) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          uart_rx = 1'b1;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    we;
    logic          busy;
    logic          frame_err;
    logic [AW:0]   word_count;

    uart_prog_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .uartRx(uart_rx),
        .addr(addr), .din(din), .we(we), .busy(busy),
        .frameErr(frame_err), .wordCount(word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: pending bytes, expected writes, address/count/error state.
    logic [7:0]  part_q[$];
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          m_addr = 0;
    int          m_wc   = 0;
    logic        m_fe   = 1'b0;

    task automatic m_accept(input logic [7:0] b);
        part_q.push_back(b);
        if (part_q.size() == 4) begin
            exp_addr_q.push_back(m_addr);
            exp_data_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
            part_q.delete();
            m_addr = (m_addr + 1) % (1 << AW);
            if (m_wc < WC_MAX) m_wc++;
        end
    endtask

    always @(negedge clk) begin : write_monitor
        int          ea;
        logic [31:0] ed;
        if (rstn && we !== 4'h0) begin
            check("we_value", 32'(we), 32'hF);
            if (exp_addr_q.size() == 0) begin
                check("spurious_write", 32'(we), 32'h0);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("write_addr", 32'(addr), ea);
                check("write_data", din, ed);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_addr"}, 32'(addr), m_addr);
        check({tag, "_wcount"}, 32'(word_count), m_wc);
        check({tag, "_ferr"}, 32'(frame_err), 32'(m_fe));
        check({tag, "_busy"}, 32'(busy), (part_q.size() != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic put_byte(input logic [7:0] b, input logic good);
        if (good) m_accept(b);
        else m_fe = 1'b1;
        send_byte(b, good);
        repeat (3) @(negedge clk);
        check_state("byte");
    endtask

    task automatic pulse_en_low(input int cycles);
        en = 1'b0;
        part_q.delete();
        repeat (cycles) @(negedge clk);
        en = 1'b1;
        m_addr = 0;
        m_wc   = 0;
        m_fe   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_din", din, 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_wcount", 32'(word_count), 32'h0);
        en = 1'b1;
        repeat (2) @(negedge clk);

        // Single word.
        put_byte(8'h78, 1'b1);
        put_byte(8'h56, 1'b1);
        put_byte(8'h34, 1'b1);
        put_byte(8'h12, 1'b1);
        check("word1_din", din, 32'h1234_5678);

        // Two consecutive words.
        pulse_en_low(3);
        for (int i = 0; i < 8; i++) put_byte(8'(i), 1'b1);
        check("two_words_din", din, 32'h0706_0504);

        // Framing error is sticky and does not disturb word assembly.
        pulse_en_low(2);
        put_byte(8'hAA, 1'b0);
        put_byte(8'hDE, 1'b1);
        put_byte(8'hAD, 1'b1);
        put_byte(8'hBE, 1'b1);
        put_byte(8'hEF, 1'b1);
        check("ferr_word_din", din, 32'hEFBE_ADDE);
        pulse_en_low(2);
        check_state("ferr_cleared");

        // Short low glitch must not start a byte.
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check_state("glitch");

        // Address wrap after 2^AW words.
        pulse_en_low(1);
        for (int i = 0; i < 20; i++) put_byte(8'($urandom_range(0, 255)), 1'b1);
        check("wrap_wcount", 32'(word_count), 32'd5);

        // Partial word discarded by a one-cycle en drop.
        pulse_en_low(1);
        put_byte(8'h11, 1'b1);
        put_byte(8'h22, 1'b1);
        pulse_en_low(1);
        put_byte(8'hA1, 1'b1);
        put_byte(8'hB2, 1'b1);
        put_byte(8'hC3, 1'b1);
        put_byte(8'hD4, 1'b1);
        check("drop_en_din", din, 32'hD4C3_B2A1);

        // Randomized traffic with occasional framing errors and en drops.
        pulse_en_low(1);
        for (int i = 0; i < 100; i++) begin
            rb = 8'($urandom_range(0, 255));
            put_byte(rb, ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) pulse_en_low($urandom_range(1, 3));
        end
        check("pending_writes", 32'(exp_addr_q.size()), 32'd0);

        // Asynchronous reset in the middle of a byte.
        uart_rx = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_byte_busy", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_addr", 32'(addr), 32'h0);
        check("arst_din", din, 32'h0);
        check("arst_we", 32'(we), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ferr", 32'(frame_err), 32'h0);
        check("arst_wcount", 32'(word_count), 32'h0);
        uart_rx = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
